// File: rtl/map_restore_engine.sv
// map_restore_engine
// Copies the pristine map ROM into map_RAM port B, one row per cycle, and
// counts pill tiles on the way. While idle, map_RAM_writer drives port B
// straight through with no added latency.
module map_restore_engine #(
  parameter int                ROWS      = 30,
  parameter int                COLS      = 40,
  parameter int                TILE_W    = 4,
  parameter int                ADDR_W    = 5,
  parameter logic [TILE_W-1:0] PILL_CODE = 4'h1,
  parameter int                COUNT_W   = 11
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [COLS*TILE_W-1:0]   rom_q,
  input  logic                     wr_req_in,
  input  logic [ADDR_W-1:0]        wr_addr_in,
  input  logic [COLS*TILE_W-1:0]   wr_data_in,
  output logic                     ram_wren,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [COLS*TILE_W-1:0]   ram_data,
  output logic                     busy,
  output logic                     done,
  output logic [COUNT_W-1:0]       pill_total
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  // Leaf count of the pill adder tree, padded up to a power of two
  localparam int NPAD = 1 << $clog2(COLS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_FINISH
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_rom_addr;
  logic [ADDR_W-1:0]    r_row_idx;
  logic [COUNT_W-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [COUNT_W-1:0]   r_pill_total;

  logic [COUNT_W-1:0]   w_tree [0:2*NPAD-2];
  logic [COUNT_W-1:0]   w_row_count;
  logic [ADDR_W-1:0]    w_rom_addr_inc;

  // Leaves: one flag per tile field of the current ROM row; padding leaves are zero
  genvar gi;
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_leaf
      if (gi < COLS) begin : g_tile
        assign w_tree[NPAD-1+gi] =
          (rom_q[gi*TILE_W +: TILE_W] == PILL_CODE) ? COUNT_W'(1) : '0;
      end else begin : g_pad
        assign w_tree[NPAD-1+gi] = '0;
      end
    end
    // Internal nodes: node n sums its two children 2n+1 and 2n+2
    for (gi = 0; gi < NPAD - 1; gi++) begin : g_node
      assign w_tree[gi] = w_tree[2*gi+1] + w_tree[2*gi+2];
    end
  endgenerate

  assign w_row_count = w_tree[0];

  // ROM row pointer runs one ahead of the row being written and parks on the last row
  assign w_rom_addr_inc = (r_rom_addr == LAST_ROW) ? LAST_ROW : r_rom_addr + ADDR_W'(1);

  // Restore sequencer: IDLE -> PRIME (ROM latency) -> STREAM (one row/cycle) -> FINISH
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_rom_addr   <= '0;
      r_row_idx    <= '0;
      r_acc        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pill_total <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_PRIME;
            r_rom_addr <= '0;
            r_row_idx  <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_PRIME: begin
          // Row 0 data arrives next cycle; request row 1 now
          r_rom_addr <= w_rom_addr_inc;
          r_row_idx  <= '0;
          r_state    <= ST_STREAM;
        end
        ST_STREAM: begin
          r_acc      <= r_acc + w_row_count;
          r_rom_addr <= w_rom_addr_inc;
          if (r_row_idx == LAST_ROW) begin
            // busy drops and done rises together so done marks the first non-busy cycle
            r_state      <= ST_FINISH;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_pill_total <= r_acc + w_row_count;
          end else begin
            r_row_idx <= r_row_idx + ADDR_W'(1);
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Port-B mux: writer passes through when idle; engine owns the port otherwise
  always_comb begin
    ram_wren = 1'b0;
    ram_addr = r_row_idx;
    ram_data = rom_q;
    case (r_state)
      ST_IDLE: begin
        ram_wren = wr_req_in;
        ram_addr = wr_addr_in;
        ram_data = wr_data_in;
      end
      ST_STREAM: begin
        ram_wren = 1'b1;
      end
      default: begin
        ram_wren = 1'b0;
      end
    endcase
  end

  assign rom_addr   = r_rom_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pill_total = r_pill_total;

endmodule
